// File: rtl/reg_wr_arbiter_pkg.sv
// Shared definitions for the register-file writeback path (also used by the apu).
package reg_wr_arbiter_pkg;

    // Default widths of the register-file write port.
    localparam int unsigned data_width_dflt    = 32;
    localparam int unsigned reg_sel_width_dflt = 5;

    // One queued register-file write.
    typedef struct packed {
        logic [reg_sel_width_dflt-1:0] sel;
        logic [data_width_dflt-1:0]    data;
    } wr_req_t;

    // Round-robin pointer: which FIFO source wins the next contended cycle.
    typedef enum logic {
        SrcApu = 1'b0,
        SrcMem = 1'b1
    } rr_src_e;

    // Write-port grant for the current cycle.
    typedef enum logic [1:0] {
        GntNone = 2'd0,
        GntCore = 2'd1,
        GntApu  = 2'd2,
        GntMem  = 2'd3
    } grant_e;

    // The source that gets priority after a FIFO grant to src.
    function automatic rr_src_e rr_other(rr_src_e src);
        return (src == SrcApu) ? SrcMem : SrcApu;
    endfunction

endpackage

// File: rtl/reg_wr_arbiter_fifo.sv
// Small synchronous FIFO of pending register writes. Head is presented
// combinationally from storage; an empty FIFO never bypasses its input.
module wr_fifo
    import reg_wr_arbiter_pkg::*;
#(
    parameter type          entry_t = wr_req_t,
    parameter int unsigned  depth   = 4,
    localparam int unsigned ptr_w   = $clog2(depth),
    localparam int unsigned cnt_w   = ptr_w + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             full,
    output logic             empty,
    output logic [cnt_w-1:0] count
);

    entry_t             mem_q [depth];
    logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [cnt_w-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    // Full/empty come only from the registered count.
    assign full  = (count_q == cnt_w'(depth));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next-state pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = ptr_w'(rd_ptr_q + 1'b1);
        end
        if (do_push) begin
            wr_ptr_d = ptr_w'(wr_ptr_q + 1'b1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = cnt_w'(count_q + 1'b1);
            2'b01:   count_d = cnt_w'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; emptied by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    pop_when_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/reg_wr_arbiter.sv
// Register-file write-port arbiter: merges core, apu and load writebacks onto one
// registered write port and tracks outstanding apu/load destinations.
module reg_wr_arbiter
    import reg_wr_arbiter_pkg::*;
#(
    parameter int unsigned  data_width    = data_width_dflt,
    parameter int unsigned  reg_sel_width = reg_sel_width_dflt,
    parameter int unsigned  fifo_depth    = 4,
    localparam int unsigned num_regs      = 2 ** reg_sel_width,
    localparam int unsigned fifo_cnt_w    = $clog2(fifo_depth) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_wr_req,
    input  logic [reg_sel_width-1:0] core_wr_sel,
    input  logic [data_width-1:0]    core_wr_data,
    input  logic                     apu_wr_req,
    input  logic [reg_sel_width-1:0] apu_wr_sel,
    input  logic [data_width-1:0]    apu_wr_data,
    input  logic                     mem_wr_req,
    input  logic [reg_sel_width-1:0] mem_wr_sel,
    input  logic [data_width-1:0]    mem_wr_data,
    input  logic                     pend_set_req,
    input  logic [reg_sel_width-1:0] pend_set_sel,
    output logic                     rf_wr_req,
    output logic [reg_sel_width-1:0] rf_wr_sel,
    output logic [data_width-1:0]    rf_wr_data,
    output logic [num_regs-1:0]      pending,
    output logic                     apu_fifo_full,
    output logic                     mem_fifo_full,
    output logic                     overflow
);

    // Same layout as wr_req_t, sized to this instance's parameters.
    typedef struct packed {
        logic [reg_sel_width-1:0] sel;
        logic [data_width-1:0]    data;
    } wr_ent_t;

    wr_ent_t                  apu_push_data, mem_push_data;
    wr_ent_t                  apu_head, mem_head;
    logic                     apu_full, mem_full;
    logic                     apu_empty, mem_empty;
    logic [fifo_cnt_w-1:0]    apu_count, mem_count;
    logic                     apu_pop, mem_pop;
    logic                     apu_drop, mem_drop;

    grant_e                   grant;
    rr_src_e                  rr_q, rr_d;

    logic                     wr_req_q, wr_req_d;
    logic [reg_sel_width-1:0] wr_sel_q, wr_sel_d;
    logic [data_width-1:0]    wr_data_q, wr_data_d;

    logic [num_regs-1:0]      pending_q, pending_d;
    logic [num_regs-1:0]      pend_set_vec, pend_clr_vec;
    logic                     overflow_q, overflow_d;

    assign apu_push_data = '{sel: apu_wr_sel, data: apu_wr_data};
    assign mem_push_data = '{sel: mem_wr_sel, data: mem_wr_data};

    wr_fifo #(
        .entry_t (wr_ent_t),
        .depth   (fifo_depth)
    ) u_apu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (apu_wr_req),
        .push_data (apu_push_data),
        .pop       (apu_pop),
        .head      (apu_head),
        .full      (apu_full),
        .empty     (apu_empty),
        .count     (apu_count)
    );

    wr_fifo #(
        .entry_t (wr_ent_t),
        .depth   (fifo_depth)
    ) u_mem_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_wr_req),
        .push_data (mem_push_data),
        .pop       (mem_pop),
        .head      (mem_head),
        .full      (mem_full),
        .empty     (mem_empty),
        .count     (mem_count)
    );

    // Pick this cycle's writer: core first, then the non-empty FIFO, round-robin on contention.
    always_comb begin
        grant = GntNone;
        if (core_wr_req) begin
            grant = GntCore;
        end else if (!apu_empty && !mem_empty) begin
            grant = (rr_q == SrcApu) ? GntApu : GntMem;
        end else if (!apu_empty) begin
            grant = GntApu;
        end else if (!mem_empty) begin
            grant = GntMem;
        end
    end

    assign apu_pop = (grant == GntApu);
    assign mem_pop = (grant == GntMem);

    // A push is lost only if the FIFO was full and its head did not leave this cycle.
    assign apu_drop = apu_wr_req && (apu_count == fifo_cnt_w'(fifo_depth)) && !apu_pop;
    assign mem_drop = mem_wr_req && (mem_count == fifo_cnt_w'(fifo_depth)) && !mem_pop;

    // Next write-port contents, round-robin pointer and scoreboard clears.
    always_comb begin
        rr_d         = rr_q;
        wr_req_d     = 1'b0;
        wr_sel_d     = wr_sel_q;
        wr_data_d    = wr_data_q;
        pend_clr_vec = '0;
        unique case (grant)
            GntCore: begin
                // Writes to register 0 are swallowed.
                if (core_wr_sel != '0) begin
                    wr_req_d  = 1'b1;
                    wr_sel_d  = core_wr_sel;
                    wr_data_d = core_wr_data;
                end
            end
            GntApu: begin
                rr_d = rr_other(SrcApu);
                if (apu_head.sel != '0) begin
                    wr_req_d                   = 1'b1;
                    wr_sel_d                   = apu_head.sel;
                    wr_data_d                  = apu_head.data;
                    pend_clr_vec[apu_head.sel] = 1'b1;
                end
            end
            GntMem: begin
                rr_d = rr_other(SrcMem);
                if (mem_head.sel != '0) begin
                    wr_req_d                   = 1'b1;
                    wr_sel_d                   = mem_head.sel;
                    wr_data_d                  = mem_head.data;
                    pend_clr_vec[mem_head.sel] = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Scoreboard update: a set in the same cycle as a clear keeps the register pending.
    always_comb begin
        pend_set_vec = '0;
        if (pend_set_req && (pend_set_sel != '0)) begin
            pend_set_vec[pend_set_sel] = 1'b1;
        end
        pending_d    = (pending_q & ~pend_clr_vec) | pend_set_vec;
        pending_d[0] = 1'b0;
        overflow_d   = overflow_q || apu_drop || mem_drop;
    end

    // Arbiter state and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= SrcApu;
            wr_req_q   <= 1'b0;
            wr_sel_q   <= '0;
            wr_data_q  <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            wr_req_q   <= wr_req_d;
            wr_sel_q   <= wr_sel_d;
            wr_data_q  <= wr_data_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign rf_wr_req     = wr_req_q;
    assign rf_wr_sel     = wr_sel_q;
    assign rf_wr_data    = wr_data_q;
    assign pending       = pending_q;
    assign overflow      = overflow_q;
    assign apu_fifo_full = apu_full;
    assign mem_fifo_full = mem_full;

    zero_reg_never_pending: assert property (@(posedge clk) disable iff (rst) !pending_q[0]);

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Randomized and directed bench for reg_wr_arbiter against a queue-based reference model.
module tb_reg_wr_arbiter;
    import reg_wr_arbiter_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;
    localparam int unsigned D  = 4;
    localparam int unsigned NR = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_wr_req = 1'b0, apu_wr_req = 1'b0, mem_wr_req = 1'b0, pend_set_req = 1'b0;
    logic [SW-1:0] core_wr_sel = '0, apu_wr_sel = '0, mem_wr_sel = '0, pend_set_sel = '0;
    logic [DW-1:0] core_wr_data = '0, apu_wr_data = '0, mem_wr_data = '0;
    logic          rf_wr_req;
    logic [SW-1:0] rf_wr_sel;
    logic [DW-1:0] rf_wr_data;
    logic [NR-1:0] pending;
    logic          apu_fifo_full, mem_fifo_full, overflow;

    reg_wr_arbiter #(
        .data_width    (DW),
        .reg_sel_width (SW),
        .fifo_depth    (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_wr_req   (core_wr_req),
        .core_wr_sel   (core_wr_sel),
        .core_wr_data  (core_wr_data),
        .apu_wr_req    (apu_wr_req),
        .apu_wr_sel    (apu_wr_sel),
        .apu_wr_data   (apu_wr_data),
        .mem_wr_req    (mem_wr_req),
        .mem_wr_sel    (mem_wr_sel),
        .mem_wr_data   (mem_wr_data),
        .pend_set_req  (pend_set_req),
        .pend_set_sel  (pend_set_sel),
        .rf_wr_req     (rf_wr_req),
        .rf_wr_sel     (rf_wr_sel),
        .rf_wr_data    (rf_wr_data),
        .pending       (pending),
        .apu_fifo_full (apu_fifo_full),
        .mem_fifo_full (mem_fifo_full),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: two queues of pending writes, a "mem goes next" flag,
    // a pending bitmap and the expected contents of the write port.
    typedef struct {
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          aq[$];
    ent_t          mq[$];
    bit            rr_mem;
    logic [NR-1:0] m_pend;
    bit            m_ovf;
    bit            m_req;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_data;

    function automatic void model_reset();
        aq.delete();
        mq.delete();
        rr_mem = 1'b0;
        m_pend = '0;
        m_ovf  = 1'b0;
        m_req  = 1'b0;
    endfunction

    function automatic void retire(input ent_t e);
        if (e.sel != '0) begin
            m_req         = 1'b1;
            m_sel         = e.sel;
            m_data        = e.data;
            m_pend[e.sel] = 1'b0;
        end
    endfunction

    // One clock edge of the reference model, using this cycle's inputs.
    function automatic void model_edge();
        ent_t e;
        m_req = 1'b0;
        if (core_wr_req) begin
            if (core_wr_sel != '0) begin
                m_req  = 1'b1;
                m_sel  = core_wr_sel;
                m_data = core_wr_data;
            end
        end else if (aq.size() > 0 && (mq.size() == 0 || !rr_mem)) begin
            e      = aq.pop_front();
            rr_mem = 1'b1;
            retire(e);
        end else if (mq.size() > 0) begin
            e      = mq.pop_front();
            rr_mem = 1'b0;
            retire(e);
        end
        if (pend_set_req && pend_set_sel != '0) m_pend[pend_set_sel] = 1'b1;
        if (apu_wr_req) begin
            if (aq.size() < D) aq.push_back('{sel: apu_wr_sel, data: apu_wr_data});
            else m_ovf = 1'b1;
        end
        if (mem_wr_req) begin
            if (mq.size() < D) mq.push_back('{sel: mem_wr_sel, data: mem_wr_data});
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic check_model();
        check("rf_wr_req", 64'(rf_wr_req), 64'(m_req));
        if (m_req) begin
            check("rf_wr_sel", 64'(rf_wr_sel), 64'(m_sel));
            check("rf_wr_data", 64'(rf_wr_data), 64'(m_data));
        end
        check("pending", 64'(pending), 64'(m_pend));
        check("apu_fifo_full", 64'(apu_fifo_full), 64'(aq.size() == D));
        check("mem_fifo_full", 64'(mem_fifo_full), 64'(mq.size() == D));
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    // Advance one clock, update the model, then compare just after the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_model();
    endtask

    task automatic idle();
        core_wr_req  = 1'b0;
        apu_wr_req   = 1'b0;
        mem_wr_req   = 1'b0;
        pend_set_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 64'(rf_wr_req), 64'(0));
        check({tag, "_sel"}, 64'(rf_wr_sel), 64'(0));
        check({tag, "_data"}, 64'(rf_wr_data), 64'(0));
        check({tag, "_pending"}, 64'(pending), 64'(0));
        check({tag, "_ovf"}, 64'(overflow), 64'(0));
        check({tag, "_afull"}, 64'(apu_fifo_full), 64'(0));
        check({tag, "_mfull"}, 64'(mem_fifo_full), 64'(0));
    endtask

    function automatic logic [SW-1:0] rnd_sel();
        if ($urandom_range(0, 7) == 0) return '0;
        return SW'($urandom_range(1, NR - 1));
    endfunction

    logic [SW-1:0] rr_sel [4];
    logic [DW-1:0] rr_dat [4];

    initial begin
        rr_sel = '{5'd5, 5'd8, 5'd6, 5'd9};
        rr_dat = '{32'd50, 32'd80, 32'd60, 32'd90};

        // Reset held for two cycles.
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        check_all_zero("reset");
        rst = 1'b0;

        // Round-robin between apu and mem, pointer starting at apu.
        apu_wr_req = 1'b1; apu_wr_sel = 5'd5; apu_wr_data = 32'd50;
        mem_wr_req = 1'b1; mem_wr_sel = 5'd8; mem_wr_data = 32'd80;
        cycle();
        apu_wr_sel = 5'd6; apu_wr_data = 32'd60;
        mem_wr_sel = 5'd9; mem_wr_data = 32'd90;
        cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycle();
            check("rr_req", 64'(rf_wr_req), 64'(1));
            check("rr_sel", 64'(rf_wr_sel), 64'(rr_sel[i]));
            check("rr_data", 64'(rf_wr_data), 64'(rr_dat[i]));
        end
        cycle();
        check("rr_done", 64'(rf_wr_req), 64'(0));

        // Single apu write, latency two cycles, clears its pending bit.
        pend_set_req = 1'b1; pend_set_sel = 5'd11;
        cycle();
        idle();
        apu_wr_req = 1'b1; apu_wr_sel = 5'd11; apu_wr_data = 32'd23;
        cycle();
        idle();
        check("apu_c1_req", 64'(rf_wr_req), 64'(0));
        check("apu_c1_pend", 64'(pending[11]), 64'(1));
        cycle();
        check("apu_c2_req", 64'(rf_wr_req), 64'(1));
        check("apu_c2_sel", 64'(rf_wr_sel), 64'(11));
        check("apu_c2_data", 64'(rf_wr_data), 64'(23));
        check("apu_c2_pend", 64'(pending[11]), 64'(0));
        cycle();
        check("apu_c3_req", 64'(rf_wr_req), 64'(0));

        // Core priority: four core writes, then the queued apu write.
        core_wr_req = 1'b1; core_wr_sel = 5'd3; core_wr_data = 32'd7;
        apu_wr_req = 1'b1; apu_wr_sel = 5'd11; apu_wr_data = 32'd23;
        cycle();
        apu_wr_req = 1'b0;
        check("core_c1_sel", 64'(rf_wr_sel), 64'(3));
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("core_req", 64'(rf_wr_req), 64'(1));
            check("core_sel", 64'(rf_wr_sel), 64'(3));
        end
        idle();
        cycle();
        check("core_apu_req", 64'(rf_wr_req), 64'(1));
        check("core_apu_sel", 64'(rf_wr_sel), 64'(11));
        check("core_apu_data", 64'(rf_wr_data), 64'(23));

        // Overflow: five apu pushes while core holds the port.
        core_wr_req = 1'b1; apu_wr_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apu_wr_sel  = SW'(i + 1);
            apu_wr_data = DW'(100 + i);
            cycle();
            check("ovf_full", 64'(apu_fifo_full), 64'(i >= 3));
            check("ovf_flag", 64'(overflow), 64'(i == 4));
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("ovf_drain_sel", 64'(rf_wr_sel), 64'(i + 1));
            check("ovf_drain_data", 64'(rf_wr_data), 64'(100 + i));
        end
        cycle();
        check("ovf_drain_end", 64'(rf_wr_req), 64'(0));
        check("ovf_sticky", 64'(overflow), 64'(1));

        // apu write to register 0 is consumed silently.
        apu_wr_req = 1'b1; apu_wr_sel = '0; apu_wr_data = 32'd55;
        cycle();
        idle();
        cycle();
        check("sel0_req", 64'(rf_wr_req), 64'(0));
        cycle();
        check("sel0_req2", 64'(rf_wr_req), 64'(0));

        // Set and clear of register 11 in the same cycle: set wins.
        pend_set_req = 1'b1; pend_set_sel = 5'd11;
        apu_wr_req = 1'b1; apu_wr_sel = 5'd11; apu_wr_data = 32'd24;
        cycle();
        apu_wr_req = 1'b0;
        cycle();
        idle();
        check("setwin_req", 64'(rf_wr_req), 64'(1));
        check("setwin_sel", 64'(rf_wr_sel), 64'(11));
        check("setwin_pend", 64'(pending[11]), 64'(1));

        // Asynchronous reset with three apu entries queued behind core.
        core_wr_req = 1'b1; core_wr_sel = 5'd4; core_wr_data = 32'd44;
        apu_wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apu_wr_sel  = SW'(20 + i);
            apu_wr_data = DW'(200 + i);
            cycle();
        end
        apu_wr_req = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        idle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("midrst_after", 64'(rf_wr_req), 64'(0));
        end

        // Randomized traffic; heavier core load in the second half to fill the FIFOs.
        for (int i = 0; i < 2000; i++) begin
            core_wr_req  = ($urandom_range(0, 99) < ((i < 1000) ? 20 : 60));
            core_wr_sel  = rnd_sel();
            core_wr_data = $urandom();
            apu_wr_req   = ($urandom_range(0, 99) < 35);
            apu_wr_sel   = rnd_sel();
            apu_wr_data  = $urandom();
            mem_wr_req   = ($urandom_range(0, 99) < 35);
            mem_wr_sel   = rnd_sel();
            mem_wr_data  = $urandom();
            pend_set_req = ($urandom_range(0, 99) < 30);
            pend_set_sel = rnd_sel();
            cycle();
        end

        idle();
        rst = 1'b1;
        cycle();
        check_all_zero("final_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
